// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream (length, big-endian words, checksum),
// writes it into instruction memory, and holds the core in reset until the image is verified.
module imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] index_q, index_d;
  logic [7:0]  sum_q, sum_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cpu_rst_q, cpu_rst_d;

  logic        loading;
  logic        accept;
  logic [15:0] len_full;
  logic [7:0]  sum_add;

  assign loading  = (state_q != S_DONE) && (state_q != S_ERR);
  assign accept   = in_valid && loading;
  assign len_full = {len_q[15:8], in_data};
  assign sum_add  = sum_q + in_data;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hi_d      = hi_q;
    index_d   = index_q;
    sum_d     = sum_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    error_d   = error_q;
    cpu_rst_d = cpu_rst_q;

    // Index advances at the end of the write cycle, so the next word's address
    // is already settled by the time its low byte can arrive.
    if (we_q) begin
      index_d = index_q + 16'd1;
    end

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          sum_d       = sum_add;
          state_d     = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          sum_d = sum_add;
          if (32'(len_full) > DEPTH) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end

      S_DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
          sum_d   = sum_add;
          state_d = S_DATA_LO;
        end
      end

      S_DATA_LO: begin
        if (accept) begin
          sum_d   = sum_add;
          we_d    = 1'b1;
          addr_d  = {index_q[14:0], 1'b0};
          wdata_d = {hi_q, in_data};
          if (index_q == len_q - 16'd1) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end

      S_CHK: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end

      S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_LEN_HI;
          index_d   = 16'd0;
          sum_d     = 8'd0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          cpu_rst_d = 1'b1;
        end
      end

      default: begin
        state_d = S_LEN_HI;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LEN_HI;
      len_q     <= 16'd0;
      hi_q      <= 8'd0;
      index_q   <= 16'd0;
      sum_q     <= 8'd0;
      we_q      <= 1'b0;
      addr_q    <= 16'd0;
      wdata_q   <= 16'd0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      index_q   <= index_d;
      sum_q     <= sum_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign in_ready   = loading;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_rst_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames, expected writes queued up front and
// checked by an independent monitor whenever imem_we is seen.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  int assertions = 0;
  int failures   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  frame [16];
  logic        prev_we = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: every write strobe is popped against the scoreboard.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      assertions++;
      if (prev_we) begin
        failures++;
        $display("FAIL we_width: imem_we high two cycles running at addr 0x%0h", imem_addr);
      end
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", imem_addr, imem_wdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          failures++;
          $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                   imem_addr, imem_wdata, e[31:16], e[15:0]);
        end else begin
          $display("ok   write addr 0x%0h data 0x%0h", imem_addr, imem_wdata);
        end
      end
    end
    prev_we = (imem_we === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Starts and ends just after a falling edge; byte transfers on the rising edge in between.
  task automatic send_byte(input logic [7:0] b);
    int tries;
    tries = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      assertions++;
      failures++;
      $display("FAIL send_timeout: in_ready=0, expected 1 for byte 0x%0h", b);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input int n, input bit bp, input bit pulse_start);
    for (int i = 0; i < n; i++) begin
      if (pulse_start && i == 2) begin
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_ready", 32'(in_ready), 32'd1);
        check("start_ignored_cpu_reset", 32'(cpu_reset), 32'd1);
      end
      send_byte(frame[i]);
      if (bp) begin
        in_valid = 1'b0;
        repeat ((i % 2 == 0) ? 3 + (i % 3) : $urandom_range(0, 1)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic load_nominal(input logic [7:0] chk);
    frame[0] = 8'h00; frame[1] = 8'h03;
    frame[2] = 8'h20; frame[3] = 8'h01;
    frame[4] = 8'h40; frame[5] = 8'h02;
    frame[6] = 8'hE0; frame[7] = 8'h03;
    frame[8] = chk;
  endtask

  task automatic push_nominal();
    exp_q.push_back({16'h0000, 16'h2001});
    exp_q.push_back({16'h0002, 16'h4002});
    exp_q.push_back({16'h0004, 16'hE003});
  endtask

  task automatic pulse_start_check(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", 32'(imem_wdata), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done_error", {30'd0, done, error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Nominal load, back-to-back bytes
    push_nominal();
    load_nominal(8'h49);
    send_frame(9, 1'b0, 1'b0);
    expect_done("nominal");
    pulse_start_check("rearm_done");

    // Bad checksum: same writes, then error
    push_nominal();
    load_nominal(8'h48);
    send_frame(9, 1'b0, 1'b0);
    check("badchk_error", 32'(error), 32'd1);
    check("badchk_done", 32'(done), 32'd0);
    check("badchk_cpu_reset", 32'(cpu_reset), 32'd1);
    check("badchk_ready", 32'(in_ready), 32'd0);
    check("badchk_pending", 32'(exp_q.size()), 32'd0);
    pulse_start_check("rearm_err");

    // Nominal again, with start pulsed while in DATA_HI
    push_nominal();
    load_nominal(8'h49);
    send_frame(9, 1'b0, 1'b1);
    expect_done("startmid");
    pulse_start_check("rearm2");

    // Empty image
    frame[0] = 8'h00; frame[1] = 8'h00; frame[2] = 8'h00;
    send_frame(3, 1'b0, 1'b0);
    expect_done("empty");
    pulse_start_check("rearm3");

    // Oversize header: N = 257
    frame[0] = 8'h01; frame[1] = 8'h01;
    send_frame(2, 1'b0, 1'b0);
    check("oversize_error", 32'(error), 32'd1);
    check("oversize_ready", 32'(in_ready), 32'd0);
    check("oversize_done", 32'(done), 32'd0);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("oversize_hold_error", 32'(error), 32'd1);
    check("oversize_hold_cpu_reset", 32'(cpu_reset), 32'd1);
    pulse_start_check("rearm4");

    // Backpressure: gaps between bytes
    push_nominal();
    load_nominal(8'h49);
    send_frame(9, 1'b1, 1'b0);
    expect_done("backpressure");
    pulse_start_check("rearm5");

    // Reset between the bytes of word index 2
    exp_q.push_back({16'h0000, 16'h2001});
    exp_q.push_back({16'h0002, 16'h4002});
    load_nominal(8'h49);
    send_frame(7, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'd0);
    check("midrst_wdata", 32'(imem_wdata), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_flags", {29'd0, cpu_reset, done, error}, 32'd4);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    push_nominal();
    send_frame(9, 1'b0, 1'b0);
    expect_done("after_reset");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
